// File: rtl/fifo_queue.sv
// Synchronous single-clock FIFO with registered read data, occupancy count and
// one-cycle overflow/underflow error pulses.
module fifo_queue #(
  parameter int DATA_SIZE      = 8,
  parameter int ADDR_SPACE_EXP = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr,
  input  logic [DATA_SIZE-1:0]      wr_data_in,
  input  logic                      rd,
  output logic [DATA_SIZE-1:0]      rd_data_out,
  output logic                      rd_valid,
  output logic                      empty,
  output logic                      full,
  output logic [ADDR_SPACE_EXP:0]   count,
  output logic                      wr_err,
  output logic                      rd_err
);

  localparam int DEPTH = 2 ** ADDR_SPACE_EXP;

  logic [DATA_SIZE-1:0]    mem [DEPTH];
  logic [ADDR_SPACE_EXP:0] wr_ptr;
  logic [ADDR_SPACE_EXP:0] rd_ptr;
  logic                    wr_ok;
  logic                    rd_ok;

  // Pointer MSB is the wrap flag: equal low bits with differing MSBs means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_SPACE_EXP-1:0] == rd_ptr[ADDR_SPACE_EXP-1:0]) &&
                 (wr_ptr[ADDR_SPACE_EXP] != rd_ptr[ADDR_SPACE_EXP]);

  always_comb begin
    rd_ok = rd & ~empty;
    wr_ok = wr & (~full | rd_ok);
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset && wr_ok)
      mem[wr_ptr[ADDR_SPACE_EXP-1:0]] <= wr_data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_data_out <= '0;
      rd_valid    <= 1'b0;
      wr_err      <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr      <= rd_ptr + 1'b1;
        rd_data_out <= mem[rd_ptr[ADDR_SPACE_EXP-1:0]];
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rd_valid <= rd_ok;
      wr_err   <= wr & ~wr_ok;
      rd_err   <= rd & ~rd_ok;
    end
  end

endmodule
